// File: rtl/wash_temp_selector.sv
// ----------------------------------------------------------------------------
// wash_temp_selector
//   Holds the user-selected wash temperature level. A per-mode default level
//   is reloaded whenever the wash mode changes, inc/dec button edges step the
//   level with wrap-around, and the setting is frozen while a cycle runs.
//
// Optional feature macro: WASH_TEMP_AUTO_REPEAT_EN
//   Defined   : holding exactly one button auto-repeats the step,
//               REPEAT_DELAY cycles after the edge step, then every
//               REPEAT_PERIOD cycles.
//   Undefined : only button edges step the level; no repeat counter is built.
//
// Ports
//   clk                    in  1       clock, rising edge
//   reset                  in  1       asynchronous, active-high
//   i_wash_mode            in  MODE_W  current wash mode
//   i_inc                  in  1       raise-temperature button level
//   i_dec                  in  1       lower-temperature button level
//   i_lock                 in  1       cycle running, setting frozen
//   o_temp_level           out LVL_W   current level index (registered)
//   o_selected_temperature out TEMP_W  TEMP_TABLE[o_temp_level] (registered)
//   o_at_default           out 1       level equals the default of latched mode
//   o_changed              out 1       one-cycle pulse on a user step
// ----------------------------------------------------------------------------
module wash_temp_selector #(
   parameter int unsigned N_LEVELS = 4,
   localparam int unsigned LVL_W = $clog2(N_LEVELS),
   parameter int unsigned TEMP_W = 7,
   parameter int unsigned MODE_W = 3,
   parameter logic [N_LEVELS*TEMP_W-1:0] TEMP_TABLE =
      {7'd60, 7'd40, 7'd30, 7'd10},
   parameter logic [(2**MODE_W)*LVL_W-1:0] MODE_MAP =
      {2'd2, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd2, 2'd2},
   parameter int unsigned REPEAT_DELAY = 8,
   parameter int unsigned REPEAT_PERIOD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [MODE_W-1:0] i_wash_mode,
   input  logic              i_inc,
   input  logic              i_dec,
   input  logic              i_lock,
   output logic [LVL_W-1:0]  o_temp_level,
   output logic [TEMP_W-1:0] o_selected_temperature,
   output logic              o_at_default,
   output logic              o_changed
);

   localparam int unsigned N_MODES = 2**MODE_W;
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_LEVELS - 1);

   // Unpacked views of the packed parameter tables.
   logic [TEMP_W-1:0] w_temp_tab [N_LEVELS];
   logic [LVL_W-1:0]  w_mode_map [N_MODES];

   for (genvar g = 0; g < N_LEVELS; g++) begin : g_temp_tab
      assign w_temp_tab[g] = TEMP_TABLE[g*TEMP_W +: TEMP_W];
   end

   for (genvar g = 0; g < N_MODES; g++) begin : g_mode_map
      assign w_mode_map[g] = MODE_MAP[g*LVL_W +: LVL_W];
   end

   logic [LVL_W-1:0]  r_level;
   logic [TEMP_W-1:0] r_temp;
   logic [MODE_W-1:0] r_mode;
   logic              r_inc_prev;
   logic              r_dec_prev;
   logic              r_changed;

   logic [LVL_W-1:0]  w_level_nxt;
   logic [MODE_W-1:0] w_mode_nxt;
   logic              w_changed_nxt;
   logic              w_inc_edge;
   logic              w_dec_edge;
   logic              w_edge_step;
   logic              w_rpt_tick;
   logic              w_step;
   logic              w_step_up;

   assign w_inc_edge  = i_inc & ~r_inc_prev;
   assign w_dec_edge  = i_dec & ~r_dec_prev;
   // Simultaneous inc and dec edges cancel each other.
   assign w_edge_step = w_inc_edge ^ w_dec_edge;

`ifdef WASH_TEMP_AUTO_REPEAT_EN
   localparam int unsigned RPT_MAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned CNT_W = $clog2(RPT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_DELAY  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(REPEAT_PERIOD);

   // r_rpt_cnt counts cycles since the last step; zero means disarmed, so
   // only an edge step can start a repeat sequence. r_rpt_run selects the
   // period threshold once the first repeat step has happened.
   logic [CNT_W-1:0] r_rpt_cnt;
   logic             r_rpt_run;
   logic [CNT_W-1:0] w_rpt_cnt_nxt;
   logic             w_rpt_run_nxt;
   logic             w_held_one;

   assign w_held_one = (i_inc & r_inc_prev & ~i_dec) |
                       (i_dec & r_dec_prev & ~i_inc);
   assign w_rpt_tick = w_held_one && (r_rpt_cnt != '0) &&
                       (r_rpt_cnt == (r_rpt_run ? CNT_PERIOD : CNT_DELAY));

   always_comb begin
      w_rpt_cnt_nxt = '0;
      w_rpt_run_nxt = 1'b0;
      if (!i_lock && (i_wash_mode == r_mode)) begin
         if (w_edge_step) begin
            w_rpt_cnt_nxt = CNT_W'(1);
         end else if (w_held_one && (r_rpt_cnt != '0)) begin
            if (w_rpt_tick) begin
               w_rpt_cnt_nxt = CNT_W'(1);
               w_rpt_run_nxt = 1'b1;
            end else begin
               w_rpt_cnt_nxt = r_rpt_cnt + CNT_W'(1);
               w_rpt_run_nxt = r_rpt_run;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rpt_cnt <= '0;
         r_rpt_run <= 1'b0;
      end else begin
         r_rpt_cnt <= w_rpt_cnt_nxt;
         r_rpt_run <= w_rpt_run_nxt;
      end
   end
`else
   assign w_rpt_tick = 1'b0;
`endif

   assign w_step    = w_edge_step | w_rpt_tick;
   // An edge step follows the edge; a repeat step follows the held button.
   assign w_step_up = w_edge_step ? w_inc_edge : i_inc;

   always_comb begin
      w_level_nxt   = r_level;
      w_mode_nxt    = r_mode;
      w_changed_nxt = 1'b0;
      if (i_lock) begin
         w_level_nxt = r_level;
      end else if (i_wash_mode != r_mode) begin
         w_mode_nxt  = i_wash_mode;
         w_level_nxt = w_mode_map[i_wash_mode];
      end else if (w_step) begin
         w_changed_nxt = 1'b1;
         if (w_step_up) begin
            w_level_nxt = (r_level == LVL_MAX) ? '0 : r_level + LVL_W'(1);
         end else begin
            w_level_nxt = (r_level == '0) ? LVL_MAX : r_level - LVL_W'(1);
         end
      end
   end

   // Reset loads the default of the mode present on the input, so the
   // outputs reflect the current mode even while reset is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode     <= i_wash_mode;
         r_level    <= w_mode_map[i_wash_mode];
         r_temp     <= w_temp_tab[w_mode_map[i_wash_mode]];
         r_inc_prev <= 1'b0;
         r_dec_prev <= 1'b0;
         r_changed  <= 1'b0;
      end else begin
         r_mode     <= w_mode_nxt;
         r_level    <= w_level_nxt;
         r_temp     <= w_temp_tab[w_level_nxt];
         r_inc_prev <= i_inc;
         r_dec_prev <= i_dec;
         r_changed  <= w_changed_nxt;
      end
   end

   assign o_temp_level           = r_level;
   assign o_selected_temperature = r_temp;
   assign o_at_default           = (r_level == w_mode_map[r_mode]);
   assign o_changed              = r_changed;

endmodule

// File: doc/wash_temp_selector.md
# wash_temp_selector

Parametrised temperature-selection block for the washing-machine controller. It holds the user-selected temperature level and reloads a per-mode default whenever the wash mode changes. It steps the level up or down on button edges with wrap-around, and freezes the setting while a cycle is running. It sits between the front-panel input synchroniser and the heater/cycle controller, which consume `selected_temperature`.

## Interface
- `N_LEVELS`, 4: number of temperature levels (≥2). `LVL_W = $clog2(N_LEVELS)`.
- `TEMP_W`, 7: temperature width in °C.
- `MODE_W`, 3: wash-mode width; there are 2^MODE_W modes.
- `TEMP_TABLE`, {60,40,30,10}: packed N_LEVELS×TEMP_W values; level i occupies bits [i*TEMP_W +: TEMP_W].
- `MODE_MAP`, levels {2,2,1,2,0,3,2,2} for modes 7..0: packed 2^MODE_W×LVL_W default level per mode.
- `REPEAT_DELAY`, 8: cycles a button must be held before auto-repeat starts.
- `REPEAT_PERIOD`, 4: cycles between auto-repeat steps.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `wash_mode` in MODE_W: current mode, synchronous to clk.
- `inc` in 1: raise-temperature button level.
- `dec` in 1: lower-temperature button level.
- `lock` in 1: high while a cycle runs; freezes the setting.
- `temp_level` out LVL_W: current level index (registered).
- `selected_temperature` out TEMP_W: TEMP_TABLE[temp_level] (registered).
- `at_default` out 1: high when temp_level equals MODE_MAP[mode_q].
- `changed` out 1: one-cycle pulse when a user step alters the level.

## Operation
- Registers: `temp_level`, `selected_temperature`, `mode_q`, `inc_prev`, `dec_prev`, `changed`, plus the repeat counter.
- Reset: `mode_q` is loaded from `wash_mode`. `temp_level` is loaded with MODE_MAP[wash_mode] and `selected_temperature` with the matching table value. `inc_prev`, `dec_prev`, `changed` and the repeat counter are cleared to 0. `at_default` is therefore 1.
- `inc_prev` and `dec_prev` track `inc` and `dec` every cycle, regardless of `lock`.
- Priority per cycle, when not in reset:
  1. `lock` = 1: no change to level or `mode_q`, no steps, `changed` = 0, repeat counter cleared.
  2. `wash_mode` ≠ `mode_q`: `mode_q` ← `wash_mode`; level ← MODE_MAP[wash_mode]. Any button edge in this cycle is discarded. `changed` = 0.
  3. Step request: rising edge of exactly one of `inc`/`dec` (or an auto-repeat tick). inc: level N_LEVELS-1 → 0, otherwise +1. dec: 0 → N_LEVELS-1, otherwise −1. `changed` = 1.
- Both edges in the same cycle cancel: no step and `changed` = 0.
- A mode change made while locked stays pending; the reload happens in the first unlocked cycle.
- `selected_temperature` always updates in the same clock edge as `temp_level`.

## Timing
- Step latency: the edge sampled at clock k produces the new level and the table value after clock k, with `changed` high for exactly that cycle.
- Mode reload latency: 1 cycle.
- `at_default` is combinational from registered state and has no extra latency.
- `reset` asserted mid-operation immediately forces the reset values and overrides everything.

## Configuration
- `WASH_TEMP_AUTO_REPEAT_EN` defined: while exactly one button stays high and the block is unlocked, an extra step occurs `REPEAT_DELAY` cycles after the edge step, then every `REPEAT_PERIOD` cycles. Each repeat step pulses `changed`. Releasing the button, pressing both buttons, a mode change or `lock` clears the counter.
- Macro undefined: only edges step the level; no repeat counter is built.

## Test plan
- Reset with `wash_mode`=2 → level 3, temperature 60, `at_default`=1, `changed`=0.
- Mode 0, three `inc` pulses → 40→60→10→30, with a `changed` pulse after each press; then one `dec` → 10.
- Mode 4 (level 2, 40), change `wash_mode` to 5 with a same-cycle `inc` edge → level 1, temperature 30, `changed`=0.
- `lock`=1, pulse `inc`, then change `wash_mode` 0→3 → output stays 40; release `lock` → 10 one cycle later.
- Simultaneous `inc`/`dec` rising edges → no change, `changed`=0. Assert `reset` mid-sequence with mode 5 → 30 immediately.
- With `WASH_TEMP_AUTO_REPEAT_EN`, hold `inc` for 20 cycles from 10 → steps at cycles 0, 8, 12, 16 giving 30, 40, 60, 10. Without the macro → only 30.
